// File: rtl/mvm_relu_requant.sv
// ReLU + round/shift requantizer from 28-bit products to 14-bit elements,
// buffered in a registered output FIFO that tags every third element.
module mvm_relu_requant #(
  parameter int SHIFT   = 4,
  parameter int RELU_EN = 1,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [27:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [13:0]       out_data,
  output logic                     out_last,
  output logic [15:0]              sat_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic signed [28:0] RND = 29'sd1 <<< (SHIFT - 1);
  localparam logic signed [28:0] MAXV = 29'sd8191;
  localparam logic signed [28:0] MINV = -29'sd8192;

  logic signed [27:0] w_relu;
  logic signed [28:0] w_rnd;
  logic signed [28:0] w_shf;
  logic signed [13:0] w_sat;
  logic               w_clip;
  logic               w_push;
  logic               w_pop;

  logic [14:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_cnt;
  logic [1:0]         r_elem;
  logic [15:0]        r_sat;

  always_comb begin
    w_relu = in_data;
    if (RELU_EN != 0 && in_data[27]) w_relu = '0;
    // 29-bit headroom keeps the rounding add from wrapping
    w_rnd  = {w_relu[27], w_relu} + RND;
    w_shf  = w_rnd >>> SHIFT;
    w_clip = 1'b0;
    w_sat  = w_shf[13:0];
    if (w_shf > MAXV) begin
      w_sat  = 14'sd8191;
      w_clip = 1'b1;
    end else if (w_shf < MINV) begin
      w_sat  = -14'sd8192;
      w_clip = 1'b1;
    end
  end

  assign in_ready   = !reset && (r_cnt != FULL);
  assign out_valid  = (r_cnt != '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign out_data   = out_valid ? signed'(r_mem[r_rptr][13:0]) : '0;
  assign out_last   = out_valid ? r_mem[r_rptr][14] : 1'b0;
  assign sat_count  = r_sat;
  assign fifo_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_elem == 2'd2, w_sat};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_elem <= '0;
      r_sat  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        r_elem <= (r_elem == 2'd2) ? 2'd0 : r_elem + 2'd1;
        if (w_clip && r_sat != 16'hFFFF) r_sat <= r_sat + 16'd1;
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: doc/mvm_relu_requant.md
MVM_RELU_REQUANT -- requirements
Module: mvm_relu_requant

Interface
REQ-001 SHALL provide parameter SHIFT, default 4: arithmetic right-shift amount applied to each product, legal range 1..14.
REQ-002 SHALL provide parameter RELU_EN, default 1: 1 enables the ReLU clamp, 0 bypasses it.
REQ-003 SHALL provide parameter DEPTH, default 4: number of output FIFO entries, a power of two, minimum 2.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL provide port in_valid, input, 1 bit: the upstream 28-bit product is valid.
REQ-007 SHALL provide port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 SHALL provide port in_data, input, 28 bits, signed: matrix-vector product element from the multiplier's output_data.
REQ-009 SHALL provide port out_valid, output, 1 bit: the FIFO head is valid.
REQ-010 SHALL provide port out_ready, input, 1 bit: downstream accepts the FIFO head.
REQ-011 SHALL provide port out_data, output, 14 bits, signed: requantized element, sized to feed the next layer's 14-bit input_data.
REQ-012 SHALL provide port out_last, output, 1 bit: out_data is the third element of a 3-element vector.
REQ-013 SHALL provide port sat_count, output, 16 bits: count of accepted words that were clipped.
REQ-014 SHALL provide port fifo_count, output, log2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 SHALL accept (push) a word only on a cycle where in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 exactly when fifo_count<DEPTH; no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 SHALL apply the ReLU step when RELU_EN=1: any negative in_data becomes 0.
REQ-018 SHALL round the ReLU result as (x + 2^(SHIFT-1)) >>> SHIFT, computed in 29 bits so the rounding add cannot overflow.
REQ-019 SHALL saturate the rounded value to [-8192, 8191].
REQ-020 SHALL increment sat_count on a push whose value was clipped, holding at 65535 once reached.
REQ-021 SHALL keep an element counter elem_cnt (0..2) that advances on each push and wraps 2->0.
REQ-022 SHALL store out_last=1 with a pushed word when elem_cnt==2.
REQ-023 SHALL register the FIFO, so a word pushed into an empty FIFO at edge N gives out_valid=1 after edge N, with no combinational in->out path.
REQ-024 SHALL pop on a cycle where out_valid=1 and out_ready=1.
REQ-025 SHALL update count correctly on simultaneous push and pop: +1 for push only, -1 for pop only, unchanged for both.
REQ-026 SHALL keep read and write pointers that wrap modulo DEPTH, and SHALL deliver output in strict FIFO order.
REQ-027 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL drive out_valid=1 exactly when fifo_count>0.
REQ-029 SHALL ignore in_data contents (X-tolerant) when in_valid=0, and out_ready when FIFO is empty.

Reset
REQ-030 SHALL, on reset assertion (asynchronous, any cycle, including mid-vector or with FIFO non-empty), immediately force fifo_count=0, out_valid=0, pointers=0, elem_cnt=0, sat_count=0, out_last=0 and out_data=0.
REQ-031 SHALL drive in_ready=0 while reset=1 and drive in_ready=1 on the first cycle after reset deasserts.
REQ-032 SHALL discard FIFO contents held before reset; these SHALL never appear at the output.

Verification
REQ-033 SHALL pass this directed scenario (RELU_EN=1, SHIFT=4): push -800, -1200, 8400 -> out 0, 0, 525; out_last 0, 0, 1; sat_count 0.
REQ-034 SHALL pass this directed scenario (RELU_EN=0, SHIFT=4): push -800, 1200, 5700 -> out -50, 75, 356; then push -400 -> out -25 with out_last=0, since elem_cnt restarted.
REQ-035 SHALL pass this directed scenario (RELU_EN=0): push 200000 then -200000 -> out 8191 then -8192, sat_count=2.
REQ-036 SHALL pass this directed scenario (DEPTH=4, out_ready=0): push 5 words -> in_ready=0 after the 4th accept and the 5th is held; then out_ready=1 -> first 4 drain in order, 5th accepted on the first freed slot.
REQ-037 SHALL pass this directed scenario: assert reset with 2 words queued and elem_cnt=1 -> out_valid=0 and fifo_count=0 immediately; next 3 pushes mark out_last only on the 3rd.
REQ-038 SHALL pass this directed scenario: random in_valid/out_ready over 300 words -> output order, values and out_last match a reference model, with no drops or duplicates.
